// File: rtl/sipo_rx_ctrl.sv
// RS232 receive front end: synchronizes rx_i, finds the start bit, samples
// mid-bit and assembles the whole frame. Optional macro: RX_FRAMING_CHECK_EN.
module sipo_rx_ctrl #(
  parameter int BaudDiv = 5208,
  parameter int Width   = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rx_i,
  output logic [Width-1:0] frame_o,
  output logic             frame_valid_o,
  output logic             busy_o,
  output logic             frame_err_o
);

  localparam int CW = $clog2(BaudDiv);
  localparam int BW = $clog2(Width);

  localparam logic [CW-1:0] HalfEnd  = CW'(BaudDiv / 2 - 1);
  localparam logic [CW-1:0] BitEnd   = CW'(BaudDiv - 1);
  localparam logic [BW-1:0] LastData = BW'(Width - 2);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state;
  logic             rx_m;
  logic             rx_s;
  logic [CW-1:0]    baud_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [Width-1:0] sreg;
  logic [Width-1:0] frame_q;
  logic             valid_q;

`ifdef RX_FRAMING_CHECK_EN
  logic             err_q;
  assign frame_err_o = err_q;
`else
  assign frame_err_o = 1'b0;
`endif

  assign frame_o       = frame_q;
  assign frame_valid_o = valid_q;
  assign busy_o        = (state != IDLE);

  // Two-flop synchronizer on the asynchronous line, idling high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_i;
      rx_s <= rx_m;
    end
  end

  // Receive FSM: one mid-bit sample per bit, frame published on the stop bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      sreg     <= '0;
      frame_q  <= '0;
      valid_q  <= 1'b0;
`ifdef RX_FRAMING_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
`ifdef RX_FRAMING_CHECK_EN
      err_q   <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (!rx_s) begin
            state <= START;
          end
        end
        START: begin
          if (baud_cnt == HalfEnd) begin
            baud_cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              sreg    <= {1'b0, sreg[Width-1:1]};
              bit_cnt <= BW'(1);
              state   <= DATA;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (baud_cnt == BitEnd) begin
            baud_cnt <= '0;
            sreg     <= {rx_s, sreg[Width-1:1]};
            bit_cnt  <= bit_cnt + BW'(1);
            if (bit_cnt == LastData) begin
              state <= STOP;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        STOP: begin
          if (baud_cnt == BitEnd) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            sreg     <= {rx_s, sreg[Width-1:1]};
            state    <= IDLE;
`ifdef RX_FRAMING_CHECK_EN
            if (rx_s) begin
              frame_q <= {rx_s, sreg[Width-1:1]};
              valid_q <= 1'b1;
            end else begin
              err_q   <= 1'b1;
            end
`else
            frame_q <= {rx_s, sreg[Width-1:1]};
            valid_q <= 1'b1;
`endif
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Directed bench for sipo_rx_ctrl with BaudDiv = 16, Width = 10.
// Build with RX_FRAMING_CHECK_EN to exercise the framing check.
module tb_sipo_rx_ctrl;

  localparam int BD = 16;
  localparam int W  = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rx  = 1'b1;
  logic [W-1:0] frame;
  logic         valid;
  logic         busy;
  logic         ferr;

  int checks = 0;
  int errors = 0;

  int           cyc = 0;
  int           vcnt = 0;
  int           ecnt = 0;
  int           vbusy = 0;
  int           last_t = 0;
  logic [W-1:0] last_frame = '0;

  sipo_rx_ctrl #(
    .BaudDiv(BD),
    .Width  (W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rx_i         (rx),
    .frame_o      (frame),
    .frame_valid_o(valid),
    .busy_o       (busy),
    .frame_err_o  (ferr)
  );

  always #5 clk = ~clk;

  // Strobe monitor sampled on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (valid) begin
      vcnt       = vcnt + 1;
      last_frame = frame;
      last_t     = cyc;
      if (busy) vbusy = vbusy + 1;
    end
    if (ferr) ecnt = ecnt + 1;
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BD) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({frame, valid, busy, ferr} !== '0) begin
      errors++;
      $display("FAIL reset_hold got %h exp 0", {frame, valid, busy, ferr});
    end
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({frame, valid, busy, ferr} !== '0) begin
      errors++;
      $display("FAIL reset_idle got %h exp 0", {frame, valid, busy, ferr});
    end
  endtask

  task automatic test_false_start;
    int v0;
    int seen_busy;
    v0 = vcnt;
    seen_busy = 0;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) seen_busy = 1;
    end
    @(posedge clk);
    #1;
    checks++;
    if (seen_busy != 1) begin
      errors++;
      $display("FAIL false_start_busy got %0d exp 1", seen_busy);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL false_start_idle got %b exp 0", busy);
    end
    checks++;
    if (vcnt != v0 || frame !== '0) begin
      errors++;
      $display("FAIL false_start_out got %0d/%h exp %0d/000",
               vcnt - v0, frame, 0);
    end
  endtask

  task automatic test_nominal;
    int          v0;
    int          blow;
    logic [9:0]  bits;
    v0   = vcnt;
    blow = 0;
    bits = 10'h34A;
    for (int k = 0; k < 10; k++) begin
      rx = bits[k];
      repeat (8) @(posedge clk);
      @(negedge clk);
      if (!busy) blow++;
      repeat (8) @(posedge clk);
      #1;
    end
    rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (vcnt != v0 + 1) begin
      errors++;
      $display("FAIL nominal_count got %0d exp 1", vcnt - v0);
    end
    checks++;
    if (last_frame !== 10'h34A) begin
      errors++;
      $display("FAIL nominal_frame got %h exp 34a", last_frame);
    end
    checks++;
    if (frame !== 10'h34A) begin
      errors++;
      $display("FAIL nominal_hold got %h exp 34a", frame);
    end
    checks++;
    if (blow != 0) begin
      errors++;
      $display("FAIL nominal_busy low_samples %0d exp 0", blow);
    end
    checks++;
    if (vbusy != 0) begin
      errors++;
      $display("FAIL strobe_busy got %0d exp 0", vbusy);
    end
  endtask

  task automatic test_back_to_back;
    int           v0;
    int           t1;
    logic [W-1:0] f1;
    v0 = vcnt;
    send_frame(8'h00, 1'b1);
    f1 = last_frame;
    t1 = last_t;
    send_frame(8'hFF, 1'b1);
    rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (vcnt != v0 + 2) begin
      errors++;
      $display("FAIL b2b_count got %0d exp 2", vcnt - v0);
    end
    checks++;
    if (f1 !== 10'h200) begin
      errors++;
      $display("FAIL b2b_first got %h exp 200", f1);
    end
    checks++;
    if (last_frame !== 10'h3FE) begin
      errors++;
      $display("FAIL b2b_second got %h exp 3fe", last_frame);
    end
    checks++;
    if (last_t - t1 != 10 * BD) begin
      errors++;
      $display("FAIL b2b_spacing got %0d exp %0d", last_t - t1, 10 * BD);
    end
  endtask

  task automatic test_framing;
    int v0;
    int e0;
    v0 = vcnt;
    e0 = ecnt;
    send_frame(8'h3C, 1'b0);
    rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
`ifdef RX_FRAMING_CHECK_EN
    checks++;
    if (ecnt != e0 + 1) begin
      errors++;
      $display("FAIL ferr_pulse got %0d exp 1", ecnt - e0);
    end
    checks++;
    if (vcnt != v0) begin
      errors++;
      $display("FAIL ferr_novalid got %0d exp 0", vcnt - v0);
    end
    checks++;
    if (frame !== 10'h3FE) begin
      errors++;
      $display("FAIL ferr_hold got %h exp 3fe", frame);
    end
`else
    checks++;
    if (vcnt != v0 + 1) begin
      errors++;
      $display("FAIL nochk_valid got %0d exp 1", vcnt - v0);
    end
    checks++;
    if (last_frame !== 10'h078) begin
      errors++;
      $display("FAIL nochk_frame got %h exp 078", last_frame);
    end
    checks++;
    if (ecnt != e0) begin
      errors++;
      $display("FAIL nochk_err got %0d exp 0", ecnt - e0);
    end
`endif
  endtask

  task automatic test_reset_mid_frame;
    int          v0;
    logic [7:0]  d;
    v0 = vcnt;
    d  = 8'hA5;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    repeat (5) @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy got %b exp 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({frame, valid, busy, ferr} !== '0) begin
      errors++;
      $display("FAIL async_reset got %h exp 0", {frame, valid, busy, ferr});
    end
    repeat (3) @(posedge clk);
    #1;
    rx  = 1'b1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (vcnt != v0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet got %0d/%b exp 0/0", vcnt - v0, busy);
    end
    send_frame(8'h81, 1'b1);
    rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (vcnt != v0 + 1 || frame !== 10'h302) begin
      errors++;
      $display("FAIL after_reset got %0d/%h exp 1/302", vcnt - v0, frame);
    end
  endtask

  initial begin
    test_reset();
    test_false_start();
    test_nominal();
    test_back_to_back();
    test_framing();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
